// File: rtl/m3cfg_pkg.sv
// Shared types and constants for the motor configuration UART receiver.
// Byte-lane layout of the default 24-bit configuration bus.
package m3cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Lane LSB positions of the 24-bit bus {pos1_neg0, perCent, speed}
  localparam int FLD_POS1_NEG0_LSB = 16;
  localparam int FLD_PERCENT_LSB   = 8;
  localparam int FLD_SPEEDH8_LSB   = 8;
  localparam int FLD_SPEEDL8_LSB   = 0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    P_HUNT,
    P_DATA,
    P_CHK
  } prs_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser plus bit-level FSM.
// Emits each good byte with a one-cycle strobe, or a framing error pulse.
module uart_rx_byte
  import m3cfg_pkg::*;
#(
  parameter int CPB = 86
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_frame_o
);

  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic          fall;
  rx_state_e     state_q;
  rx_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          ferr_q;
  logic          stop_ok;
  logic          stop_bad;

  assign fall = prev_q & ~sync2_q;

  // Two-flop synchroniser and edge-detect history, idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Bit FSM next state: mid-start glitch reject, 8 data bits, stop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: begin
        if (cnt_q == HALF)
          state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (cnt_q == LAST && bit_q == 3'd7)
          state_d = RX_STOP;
      end
      RX_STOP:  if (cnt_q == LAST) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Bit FSM outputs: counter, bit index, shifter and stop verdict
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      RX_IDLE: cnt_d = '0;
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bit_d   = bit_q + 1'b1;
          shift_d = {sync2_q, shift_q[7:1]};
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          stop_ok  = sync2_q;
          stop_bad = ~sync2_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= stop_ok;
      ferr_q  <= stop_bad;
      if (stop_ok) byte_q <= shift_q;
    end
  end

  assign byte_o      = byte_q;
  assign valid_o     = valid_q;
  assign err_frame_o = ferr_q;

endmodule

// File: rtl/uart_rx_set_config.sv
// Frame parser on top of uart_rx_byte: A5, data bytes MSB first, sum.
// A verified frame replaces the live configuration bus.
module uart_rx_set_config
  import m3cfg_pkg::*;
#(
  parameter int CLK_HZ    = 10_000_000,
  parameter int BAUD      = 115200,
  parameter int busWIDTH  = 24,
  parameter int TOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uRx,
  input  logic [busWIDTH-1:0] busDefault,
  output logic [busWIDTH-1:0] busNow,
  output logic                cfgUpdate,
  output logic [7:0]          rxByte,
  output logic                rxValid,
  output logic                errFrame,
  output logic                errChk
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int NBYTE = busWIDTH / 8;
  localparam int IW    = $clog2(NBYTE + 1);
  localparam int TW    = $clog2(TOUT_BITS * CPB + 1);
  localparam logic [IW-1:0] LASTIDX = IW'(NBYTE - 1);
  localparam logic [TW-1:0] TLIM    = TW'(TOUT_BITS * CPB);

  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                rx_ferr;
  logic                timeout;
  prs_state_e          pst_q;
  prs_state_e          pst_d;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic [7:0]          sum_q;
  logic [7:0]          sum_d;
  logic [busWIDTH-1:0] stage_q;
  logic [busWIDTH-1:0] stage_d;
  logic [busWIDTH-1:0] cfg_q;
  logic [busWIDTH-1:0] cfg_d;
  logic                loaded_q;
  logic                loaded_d;
  logic                upd_q;
  logic                upd_d;
  logic                echk_q;
  logic                echk_d;
  logic [TW-1:0]       tout_q;
  logic [TW-1:0]       tout_d;

  uart_rx_byte #(
    .CPB(CPB)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (uRx),
    .byte_o     (rx_byte),
    .valid_o    (rx_valid),
    .err_frame_o(rx_ferr)
  );

  // A stalled frame expires; a completing byte or framing error wins
  assign timeout = (pst_q != P_HUNT) && (tout_q == TLIM) &&
                   !rx_valid && !rx_ferr;

  // Parser state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pst_q <= P_HUNT;
    else     pst_q <= pst_d;
  end

  // Parser next state; framing error and timeout force a resync
  always_comb begin
    pst_d = pst_q;
    if (rx_ferr || timeout) begin
      pst_d = P_HUNT;
    end else if (rx_valid) begin
      unique case (pst_q)
        P_HUNT: if (rx_byte == SYNC_BYTE) pst_d = P_DATA;
        P_DATA: if (idx_q == LASTIDX) pst_d = P_CHK;
        P_CHK:  pst_d = P_HUNT;
        default: pst_d = P_HUNT;
      endcase
    end
  end

  // Parser outputs: staging, running sum, commit and error pulses
  always_comb begin
    idx_d    = idx_q;
    sum_d    = sum_q;
    stage_d  = stage_q;
    cfg_d    = cfg_q;
    loaded_d = loaded_q;
    upd_d    = 1'b0;
    echk_d   = 1'b0;
    tout_d   = (pst_q == P_HUNT || rx_valid) ? '0 : tout_q + 1'b1;
    unique case (1'b1)
      rx_ferr: ;
      timeout: echk_d = 1'b1;
      rx_valid && pst_q == P_HUNT: begin
        idx_d = '0;
        sum_d = '0;
      end
      rx_valid && pst_q == P_DATA: begin
        stage_d = busWIDTH'({stage_q, rx_byte});
        sum_d   = sum_q + rx_byte;
        idx_d   = idx_q + 1'b1;
      end
      rx_valid && pst_q == P_CHK: begin
        if (rx_byte == sum_q) begin
          cfg_d    = stage_q;
          loaded_d = 1'b1;
          upd_d    = 1'b1;
        end else begin
          echk_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Parser datapath and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      sum_q    <= '0;
      stage_q  <= '0;
      cfg_q    <= '0;
      loaded_q <= 1'b0;
      upd_q    <= 1'b0;
      echk_q   <= 1'b0;
      tout_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      stage_q  <= stage_d;
      cfg_q    <= cfg_d;
      loaded_q <= loaded_d;
      upd_q    <= upd_d;
      echk_q   <= echk_d;
      tout_q   <= tout_d;
    end
  end

  assign busNow    = loaded_q ? cfg_q : busDefault;
  assign cfgUpdate = upd_q;
  assign errChk    = echk_q;
  assign rxByte    = rx_byte;
  assign rxValid   = rx_valid;
  assign errFrame  = rx_ferr;

endmodule

// File: doc/uart_rx_set_config.md
# uart_rx_set_config

Receive-side counterpart of the configuration display UART. Deserialises 8N1 bytes on `uRx`, assembles checksummed binary frames and updates the live motor configuration bus (`{pos1_neg0, perCent, speedH8, speedL8}`). Until the first valid frame arrives, the bus passes through `busDefault`. It sits in the 10 MHz `clkM3` domain beside the transmitter.

## Interface
- `CLK_HZ`, 10_000_000: clock frequency.
- `BAUD`, 115200: line rate. `CPB = CLK_HZ/BAUD` (truncating division; 86 at the defaults).
- `busWIDTH`, 24: configuration bus width; must be a multiple of 8. `NBYTE = busWIDTH/8`.
- `TOUT_BITS`, 20: idle bit-times allowed between bytes inside a frame.
- `clk` in 1: system clock (10 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `uRx` in 1: serial input, idle high, asynchronous to `clk`.
- `busDefault` in busWIDTH: configuration used before the first valid frame.
- `busNow` out busWIDTH: current configuration.
- `cfgUpdate` out 1: one-cycle pulse when `busNow` takes a new frame.
- `rxByte` out 8: last received byte.
- `rxValid` out 1: one-cycle strobe for `rxByte`.
- `errFrame` out 1: one-cycle pulse on a bad stop bit.
- `errChk` out 1: one-cycle pulse on a checksum mismatch or inter-byte timeout.

## Operation
- **Input sync:** 2-flop synchroniser on `uRx`, reset to 1.
- **Bit receiver FSM** (IDLE, START, DATA, STOP):
  - IDLE → START on synchronised falling edge; bit counter cleared.
  - START: at count `CPB/2`, if the line is still 0 → DATA, else → IDLE (glitch reject, no error).
  - DATA: sample every `CPB` clocks. 8 bits, LSB first, shifted into `rxByte`.
  - STOP: sample at `CPB`.
    - If 1: `rxValid` pulse, byte handed to the parser.
    - If 0: `errFrame` pulse, byte discarded, parser forced to HUNT.
  - Returns to IDLE immediately after the stop sample. This allows back-to-back frames.
- **Frame parser FSM** (HUNT, DATA, CHK). Frame = `0xA5`, NBYTE data bytes MSB-first, checksum.
  - Checksum = 8-bit sum mod 256 of the data bytes.
  - HUNT: `0xA5` → DATA with index cleared; any other byte is ignored.
  - DATA: shift byte into the staging register. The checksum accumulator adds the byte (8-bit wrap). After NBYTE bytes → CHK. A data byte of value `0xA5` is data, not a resync.
  - CHK: on match, copy staging to `cfgReg`, set `loaded`, pulse `cfgUpdate`. On mismatch, pulse `errChk`. Both cases → HUNT.
  - Timeout: in DATA or CHK, if no byte completes within `TOUT_BITS*CPB` clocks of the previous one → HUNT with an `errChk` pulse.
- **Output:** `busNow = loaded ? cfgReg : busDefault` (combinational mux).
- **Reset values:**
  - `busNow` = `busDefault` (`loaded` = 0, `cfgReg` = 0).
  - `rxByte` = 0x00.
  - `cfgUpdate`, `rxValid`, `errFrame`, `errChk` = 0.
  - Both FSMs in IDLE/HUNT.
- **Reset mid-frame:** partial staging is discarded. The next byte is parsed from HUNT.

## Timing
- Stop bit sampled `CPB/2 + 9*CPB` clocks after the start edge (±2 clocks from synchroniser and edge detect). `rxValid` is registered and asserts on the cycle after the stop sample.
- `cfgUpdate` asserts 1 cycle after the `rxValid` of the checksum byte. `busNow` changes on the same edge as `cfgUpdate` goes high.
- `rxValid` and `cfgUpdate`/`errChk` are never asserted for the same byte in the same cycle. Pulses are exactly 1 clock wide.
- Timeout counter is cleared on every `rxValid`. Its width is `$clog2(TOUT_BITS*CPB+1)`.
- `errFrame` and `errChk` never assert in the same cycle.

## Structure
- **Shared package `m3cfg_pkg`:**
  - `SYNC_BYTE = 8'hA5`.
  - Default bus field layout: bit positions of `pos1_neg0`, `perCent`, `speedH8`, `speedL8`.
  - Receiver state and parser state enumerations.
- **Sub-module `uart_rx_byte`:** synchroniser plus bit FSM; outputs `rxByte`, `rxValid`, `errFrame`. It is reusable by other command inputs.
- **Top `uart_rx_set_config`:** parser, timeout, `cfgReg`, output mux.

## Test plan
- **Reset:** assert `rst` with `busDefault=24'h010A01` → `busNow=24'h010A01`, all pulses 0. Change `busDefault` to `24'h010A64` → `busNow` follows.
- **Valid frame:** send `A5 01 14 02 17` at 115200 → one `cfgUpdate`, `busNow=24'h011402`, four-plus-one `rxValid` strobes. Later `busDefault` changes are ignored.
- **Bad checksum:** send `A5 01 14 02 18` → one `errChk` pulse, no `cfgUpdate`, `busNow` unchanged.
- **Framing error:** send `A5 01` then a byte with stop bit 0 → `errFrame`. Then send the full good frame `A5 00 32 00 32` → `busNow=24'h003200`.
- **Glitch and timeout:**
  - 20-clock low pulse on idle `uRx` → no `rxValid`.
  - `A5 01`, then idle for 25 bit-times → `errChk`, parser back in HUNT.
- **Back-to-back and reset:**
  - Two frames with zero idle gap → two `cfgUpdate` pulses, final value from the second frame.
  - `rst` asserted after 2 data bytes → staging dropped, `busNow=busDefault`.
